// File: rtl/inst_mem_loader.sv
// inst_mem_loader: run-time loadable instruction memory with registered, range-checked fetch port
//   Clk/Clrn            clock, synchronous active-low reset
//   Req/Addr            fetch request and byte address
//   Inst/Ivalid/Fault   registered fetch result, valid pulse, misaligned/out-of-range flag
//   Busy                loader active, fetches refused
//   Ld_start/Ld_valid/Ld_last/Ld_data/Ld_ready   sequential program loader handshake
//   Ld_cnt/Ld_err       words written by current/last load, sticky truncation flag
module inst_mem_loader #(
  parameter int DEPTH_BITS = 5,
  parameter logic [31:0] FILL = 32'h0000_0000
) (
  input  logic                  Clk,
  input  logic                  Clrn,
  input  logic                  Req,
  input  logic [31:0]           Addr,
  output logic [31:0]           Inst,
  output logic                  Ivalid,
  output logic                  Fault,
  output logic                  Busy,
  input  logic                  Ld_start,
  input  logic                  Ld_valid,
  input  logic                  Ld_last,
  input  logic [31:0]           Ld_data,
  output logic                  Ld_ready,
  output logic [DEPTH_BITS:0]   Ld_cnt,
  output logic                  Ld_err
);
  localparam int DEPTH = 2 ** DEPTH_BITS;
  typedef enum logic {RUN, LOAD} state_t;
  state_t state, state_nx;
  logic [31:0] mem [DEPTH];
  logic [DEPTH-1:0] written;
  logic [DEPTH_BITS-1:0] ptr, idx;
  logic start, accept, beat, at_end, fault;
  assign idx = Addr[DEPTH_BITS+1:2];
  assign Busy = state == LOAD;
  assign Ld_ready = state == LOAD;
  always_comb begin
    start = state == RUN && Ld_start;
    accept = state == RUN && Req;
    beat = state == LOAD && Ld_valid;
    at_end = ptr == DEPTH_BITS'(DEPTH - 1);
    fault = (|Addr[1:0]) || (|Addr[31:DEPTH_BITS+2]);
    state_nx = start ? LOAD : (beat && (Ld_last || at_end)) ? RUN : state;
  end
  always_ff @(posedge Clk)
    if (!Clrn) state <= RUN;
    else state <= state_nx;
  // array contents survive reset; the written bits alone decide what reads back
  always_ff @(posedge Clk)
    if (Clrn && beat) mem[ptr] <= Ld_data;
  always_ff @(posedge Clk)
    if (!Clrn) begin
      written <= '0;
      ptr <= '0;
      Ld_cnt <= '0;
      Ld_err <= 1'b0;
    end else if (start) begin
      written <= '0;
      ptr <= '0;
      Ld_cnt <= '0;
      Ld_err <= 1'b0;
    end else if (beat) begin
      written[ptr] <= 1'b1;
      ptr <= ptr + 1'b1;
      Ld_cnt <= Ld_cnt + 1'b1;
      if (at_end && !Ld_last) Ld_err <= 1'b1;
    end
  // fetch samples pre-load contents even when Ld_start arrives on the same edge
  always_ff @(posedge Clk)
    if (!Clrn) begin
      Inst <= '0;
      Ivalid <= 1'b0;
      Fault <= 1'b0;
    end else begin
      Ivalid <= accept;
      if (accept) begin
        Fault <= fault;
        Inst <= (fault || !written[idx]) ? FILL : mem[idx];
      end
    end
endmodule

// File: doc/inst_mem_loader.md
# inst_mem_loader

Parametrised instruction memory for the single-cycle/multicycle CPU datapath, replacing the fixed combinational program ROM. Holds DEPTH words of 32-bit instructions, written at run time by a sequential program loader. Serves fetches through a registered one-cycle read port with alignment and range checking. Sits between the PC register and the instruction decoder; the loader side connects to the board's program-download path.

## Interface
- DEPTH_BITS, 5, log2 of word depth; DEPTH = 2**DEPTH_BITS words
- FILL, 32'h0000_0000, word returned for never-written locations (sll $0,$0,0 = nop)

- Clk  in  1  clock; all state changes on rising edge
- Clrn  in  1  reset, synchronous, active-low
- Req  in  1  fetch request, sampled on Clk edge
- Addr  in  32  byte address of fetch; word index = Addr[DEPTH_BITS+1:2]
- Inst  out  32  fetched instruction, registered
- Ivalid  out  1  Inst/Fault valid this cycle, one-cycle pulse per accepted Req
- Fault  out  1  accepted fetch was misaligned or out of range
- Busy  out  1  loader active; fetches not accepted
- Ld_start  in  1  begin a program load
- Ld_valid  in  1  Ld_data holds a word to write
- Ld_last  in  1  qualifies final word of a load
- Ld_data  in  32  instruction word to write
- Ld_ready  out  1  loader accepts a word this cycle
- Ld_cnt  out  DEPTH_BITS+1  words written by current/last load
- Ld_err  out  1  sticky: load truncated at full depth without Ld_last

## Operation
- Storage: DEPTH x 32 array plus DEPTH per-word written bits (flops). Reading an entry whose written bit is 0 returns FILL.
- States: RUN (after reset), LOAD.
- RUN: Ld_ready=0, Busy=0. Req=1 accepts a fetch. Ld_start=1 -> LOAD next cycle; on that edge clear all written bits, write pointer=0, Ld_cnt=0, Ld_err=0. Ld_valid/Ld_last ignored in RUN.
- LOAD: Busy=1, Ld_ready=1. Beat = Ld_valid & Ld_ready: write Ld_data to mem[ptr], set written[ptr], ptr+1, Ld_cnt+1.
  - Beat with Ld_last=1 -> RUN.
  - Beat at ptr=DEPTH-1 -> RUN regardless; if Ld_last=0 on that beat, Ld_err=1.
  - Req ignored (no Ivalid); Ld_start ignored.
- Fetch check: Fault=1 if Addr[1:0]!=0 or Addr[31:DEPTH_BITS+2]!=0. Faulting fetch returns Inst=FILL.
- Simultaneous Req and Ld_start in RUN: fetch completes against pre-load contents (Ivalid next cycle), then LOAD entered.
- Word count wraps impossible: Ld_cnt max = DEPTH.

## Timing
- Reset (Clrn=0 at edge): state=RUN, Inst=0, Ivalid=0, Fault=0, Busy=0, Ld_ready=0, Ld_cnt=0, Ld_err=0, ptr=0, all written bits=0 (memory reads FILL). Array contents not required to clear.
- Reset mid-load: same as above; partial program discarded.
- Fetch latency: Req at edge N -> Inst/Fault valid with Ivalid=1 during cycle N+1. Back-to-back Req each cycle gives one result per cycle.
- Inst and Fault hold last values while Ivalid=0.
- Busy/Ld_ready assert the cycle after the Ld_start edge; deassert the cycle after the final beat's edge.
- A word written at edge N is readable by a fetch accepted at edge N+1 or later (only possible after LOAD exits).

## Test plan
- Reset then Req, Addr=0x0 -> Ivalid=1 next cycle, Inst=0x00000000, Fault=0; Ld_cnt=0.
- Load 3 words 0x3401000A, 0x20020006, 0x00221824 (Ld_last on third, Ld_valid gapped one cycle between 1 and 2) -> Ld_cnt=3, Busy low after; fetch Addr=0x8 -> Inst=0x00221824; Addr=0xC -> FILL.
- Fetch Addr=0x6 -> Fault=1, Inst=FILL; Addr=0x80 (DEPTH_BITS=5) -> Fault=1.
- Load 32 words, Ld_last never asserted -> auto-exit after 32nd beat, Ld_cnt=32, Ld_err=1; next Ld_start clears Ld_err.
- Req and Ld_start same cycle -> Ivalid with old word, then Busy=1; Req during LOAD -> no Ivalid.
- Clrn=0 after 2 beats of a load -> Busy=0, Ld_cnt=0, fetch Addr=0x0 returns FILL.
